// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: shared sequencer state encoding and datapath stage indices
package nn_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FLUSH, S_RUN, S_DONE, S_ERROR} seq_state_t;
  localparam int STAGE_POOL = 0;
  localparam int STAGE_DENSE1 = 1;
  localparam int STAGE_DENSE2 = 2;
  localparam int STAGE_ARGMAX = 3;
endpackage

// File: rtl/stage_timer.sv
// stage_timer: restartable up-counter (restart loads 1) that holds at LIMIT and flags tc there; ports clock, reset, restart -> tc
module stage_timer #(
  parameter int LIMIT = 65535
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tc
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc = cnt_q == W'(LIMIT);
  always_comb cnt_d = restart ? W'(1) : tc ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clock)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/nn_inference_sequencer.sv
// nn_inference_sequencer: start -> clear -> flush -> one-hot stage enables with watchdog; reports result_valid, error/error_stage, cycle_count
module nn_inference_sequencer
  import nn_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W = 24
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [NUM_STAGES-1:0]                 stage_done,
  output logic [NUM_STAGES-1:0]                 stage_enable,
  output logic                                  stage_clear,
  output logic                                  busy,
  output logic                                  result_valid,
  output logic                                  error,
  output logic [$clog2(NUM_STAGES+1)-1:0]       error_stage,
  output logic [$clog2(NUM_STAGES)-1:0]         current_stage,
  output logic [CNT_W-1:0]                      cycle_count
);
  localparam int SW = $clog2(NUM_STAGES);
  localparam int EW = $clog2(NUM_STAGES + 1);
  seq_state_t state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [CNT_W-1:0] run_q, run_d, cnt_q, cnt_d;
  logic err_q, err_d;
  logic [EW-1:0] err_stage_q, err_stage_d;
  logic restart, tc;
  // one timer serves both the flush wait and every stage; any state or stage change restarts it
  assign restart = state_d != state_q || stage_d != stage_q;
  stage_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clock(clock),
    .reset(reset),
    .restart(restart),
    .tc(tc)
  );
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d = cnt_q;
    err_d = err_q;
    err_stage_d = err_stage_q;
    run_d = (state_q inside {S_CLEAR, S_FLUSH, S_RUN}) && run_q != '1 ? run_q + 1'b1 : run_q;
    if (state_q != S_IDLE && abort) state_d = S_IDLE;
    else
      case (state_q)
        S_IDLE:
          if (start) begin
            state_d = S_CLEAR;
            stage_d = SW'(STAGE_POOL);
            run_d = '0;
            err_d = 1'b0;
            err_stage_d = '0;
          end
        S_CLEAR: state_d = S_FLUSH;
        S_FLUSH:
          if (stage_done == '0) begin
            state_d = S_RUN;
            stage_d = SW'(STAGE_POOL);
          end else if (tc) begin
            state_d = S_ERROR;
            err_d = 1'b1;
            err_stage_d = EW'(NUM_STAGES);
          end
        S_RUN:
          if (stage_done[stage_q]) begin
            state_d = stage_q == SW'(NUM_STAGES - 1) ? S_DONE : S_RUN;
            stage_d = stage_q == SW'(NUM_STAGES - 1) ? stage_q : stage_q + 1'b1;
          end else if (tc) begin
            state_d = S_ERROR;
            err_d = 1'b1;
            err_stage_d = EW'(stage_q);
          end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d = run_q;
        end
        default: state_d = S_IDLE;
      endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      run_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      run_q <= run_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      err_stage_q <= err_stage_d;
    end
  assign stage_enable = state_q == S_RUN ? NUM_STAGES'(1) << stage_q : '0;
  assign stage_clear = state_q == S_CLEAR;
  assign busy = state_q != S_IDLE;
  assign result_valid = state_q == S_DONE;
  assign error = err_q;
  assign error_stage = err_stage_q;
  assign current_stage = stage_q;
  assign cycle_count = cnt_q;
endmodule
